// File: rtl/axi_stream_input.sv
// AXI-Stream slave that lands NPU input tensors in the input SRAM through a 2-entry skid FIFO.
// Optional tlast checking is compiled in with `define AXIS_IN_LAST_CHECK_EN.
module axi_stream_input #(
    parameter int MAX_ADDR_WIDTH     = 13,
    parameter int SRAM_WIDTH_I       = 64,
    parameter int NUM_CHANNELS_WIDTH = 7
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic [SRAM_WIDTH_I-1:0]       s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
    output logic                          sram_in_en,
    output logic                          sram_in_we,
    output logic [MAX_ADDR_WIDTH-1:0]     sram_in_addr,
    output logic [SRAM_WIDTH_I-1:0]       sram_in_data,
    input  logic                          sram_in_stall,
    input  logic                          start_input,
    input  logic [MAX_ADDR_WIDTH-1:0]     in_size,
    input  logic [3:0]                    groups,
    output logic [NUM_CHANNELS_WIDTH-1:0] channels,
    output logic                          input_done,
    output logic                          err_last
);

    localparam int CW = MAX_ADDR_WIDTH + 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic                          start_prev_q;
    logic [MAX_ADDR_WIDTH-1:0]     in_size_q, in_size_d;
    logic [3:0]                    groups_q, groups_d;
    logic [CW-1:0]                 elem_cnt_q, elem_cnt_d;
    logic [MAX_ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [SRAM_WIDTH_I-1:0]       mem_q [2];
    logic [SRAM_WIDTH_I-1:0]       mem_d [2];
    logic                          wr_ptr_q, wr_ptr_d;
    logic                          rd_ptr_q, rd_ptr_d;
    logic [1:0]                    count_q, count_d;
    logic                          tready_q, tready_d;
    logic                          en_q, en_d;
    logic [MAX_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [SRAM_WIDTH_I-1:0]       data_q, data_d;
    logic [NUM_CHANNELS_WIDTH-1:0] channels_q, channels_d;
    logic                          first_q, first_d;
    logic                          done_q, done_d;
`ifdef AXIS_IN_LAST_CHECK_EN
    logic                          err_last_q, err_last_d;
`endif

    logic          arm, active, abort, accept, pop, final_beat, end_beat;
    logic [CW-1:0] cnt_next;

    always_comb begin
        arm        = start_input && !start_prev_q;
        active     = (state_q == S_RECV) || (state_q == S_DRAIN);
        abort      = active && !start_input;
        accept     = s_axis_tvalid && tready_q && (state_q == S_RECV) && !abort;
        pop        = active && !abort && (count_q != 2'd0) && !sram_in_stall;
        cnt_next   = elem_cnt_q + CW'(groups_q);
        final_beat = cnt_next >= CW'(in_size_q);
`ifdef AXIS_IN_LAST_CHECK_EN
        end_beat   = final_beat || s_axis_tlast;
`else
        end_beat   = final_beat;
`endif

        state_d    = state_q;
        in_size_d  = in_size_q;
        groups_d   = groups_q;
        elem_cnt_d = elem_cnt_q;
        wr_addr_d  = wr_addr_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        en_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        channels_d = channels_q;
        first_d    = first_q;
`ifdef AXIS_IN_LAST_CHECK_EN
        err_last_d = err_last_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    in_size_d  = in_size;
                    groups_d   = (groups == 4'd0) ? 4'd1 : groups;
                    elem_cnt_d = '0;
                    wr_addr_d  = '0;
                    first_d    = 1'b1;
`ifdef AXIS_IN_LAST_CHECK_EN
                    err_last_d = 1'b0;
`endif
                    state_d    = (in_size == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    elem_cnt_d = cnt_next;
                    if (first_q) begin
                        channels_d = s_axis_tuser;
                        first_d    = 1'b0;
                    end
`ifdef AXIS_IN_LAST_CHECK_EN
                    // Early tlast and missing tlast on the final beat are both mismatches.
                    if (s_axis_tlast != final_beat) err_last_d = 1'b1;
`endif
                    if (end_beat) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) state_d = S_IDLE;
                else if (count_q == 2'd0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = s_axis_tdata;
                wr_ptr_d        = !wr_ptr_q;
            end
            if (pop) begin
                en_d      = 1'b1;
                addr_d    = wr_addr_q;
                data_d    = mem_q[rd_ptr_q];
                rd_ptr_d  = !rd_ptr_q;
                wr_addr_d = wr_addr_q + MAX_ADDR_WIDTH'(groups_q);
            end
            count_d = count_q + 2'(accept) - 2'(pop);
        end

        // tready is registered, so it looks at the occupancy the FIFO will have next cycle.
        tready_d = (state_d == S_RECV) && (count_d != 2'd2);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            in_size_q    <= '0;
            groups_q     <= '0;
            elem_cnt_q   <= '0;
            wr_addr_q    <= '0;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            tready_q     <= 1'b0;
            en_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            channels_q   <= '0;
            first_q      <= 1'b0;
            done_q       <= 1'b0;
`ifdef AXIS_IN_LAST_CHECK_EN
            err_last_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_input;
            in_size_q    <= in_size_d;
            groups_q     <= groups_d;
            elem_cnt_q   <= elem_cnt_d;
            wr_addr_q    <= wr_addr_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tready_q     <= tready_d;
            en_q         <= en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            channels_q   <= channels_d;
            first_q      <= first_d;
            done_q       <= done_d;
`ifdef AXIS_IN_LAST_CHECK_EN
            err_last_q   <= err_last_d;
`endif
        end
    end

    assign s_axis_tready = tready_q;
    assign sram_in_en    = en_q;
    assign sram_in_we    = en_q;
    assign sram_in_addr  = addr_q;
    assign sram_in_data  = data_q;
    assign channels      = channels_q;
    assign input_done    = done_q;
`ifdef AXIS_IN_LAST_CHECK_EN
    assign err_last      = err_last_q;
`else
    assign err_last      = 1'b0;
    logic unused_tlast;
    assign unused_tlast  = s_axis_tlast;
`endif

endmodule

// File: tb/tb_axi_stream_input.sv
// Scoreboard bench for axi_stream_input: expected SRAM writes queued at stimulus time,
// checked by an independent monitor on every sram_in_en cycle.
module tb_axi_stream_input;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int UW = 7;
    localparam int EW = AW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [UW-1:0] s_axis_tuser;
    logic          sram_in_en;
    logic          sram_in_we;
    logic [AW-1:0] sram_in_addr;
    logic [DW-1:0] sram_in_data;
    logic          sram_in_stall;
    logic          start_input;
    logic [AW-1:0] in_size;
    logic [3:0]    groups;
    logic [UW-1:0] channels;
    logic          input_done;
    logic          err_last;

    axi_stream_input dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .sram_in_en    (sram_in_en),
        .sram_in_we    (sram_in_we),
        .sram_in_addr  (sram_in_addr),
        .sram_in_data  (sram_in_data),
        .sram_in_stall (sram_in_stall),
        .start_input   (start_input),
        .in_size       (in_size),
        .groups        (groups),
        .channels      (channels),
        .input_done    (input_done),
        .err_last      (err_last)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks   = 0;
    int n_err      = 0;
    int done_cnt   = 0;
    int done_cyc   = -1;
    int first_wr   = -1;
    int last_wr    = -1;
    int stall_pct  = 0;
    int stall_hold = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (sram_in_en) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", sram_in_addr, sram_in_data);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk("write_we", sram_in_we, 1'b1);
                    chk("write_addr", sram_in_addr, e[EW-1:DW]);
                    chk("write_data", sram_in_data, e[DW-1:0]);
                end
            end
            if (input_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // SRAM stall generator; runs after the driver within each cycle.
    initial begin
        sram_in_stall = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (stall_hold > 0) begin
                sram_in_stall = 1'b1;
                stall_hold--;
            end else begin
                sram_in_stall = ($urandom_range(0, 99) < stall_pct);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int size, input int g);
        tick();
        start_input = 1'b0;
        tick();
        in_size     = AW'(size);
        groups      = 4'(g);
        start_input = 1'b1;
        done_cnt    = 0;
        done_cyc    = -1;
        first_wr    = -1;
        last_wr     = -1;
    endtask

    // Holds one beat on the bus until it is accepted or max_cyc cycles pass.
    task automatic offer(input logic [DW-1:0] d, input logic [UW-1:0] u, input bit l,
                         input int max_cyc, output bit ok);
        bit acc;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            acc = s_axis_tready;
            tick();
            if (acc) ok = 1'b1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // One complete transfer; the reference model decides how many beats land and where.
    task automatic run_xfer(input int size, input int g, input int tlast_idx, input int stall_p,
                            input int hold, input bit timing);
        int geff, nc, n, c1;
        bit err_exp, ok;
        logic [DW-1:0] d;
        logic [UW-1:0] u, ch_exp;
        geff = (g == 0) ? 1 : g;
        nc   = (size + geff - 1) / geff;
        n    = nc;
        err_exp = 1'b0;
        ch_exp  = '0;
        c1      = 0;
`ifdef AXIS_IN_LAST_CHECK_EN
        if (tlast_idx >= 0 && tlast_idx < nc - 1) begin
            n = tlast_idx + 1;
            err_exp = 1'b1;
        end else if (tlast_idx != nc - 1) begin
            err_exp = 1'b1;
        end
`endif
        stall_pct = stall_p;
        arm(size, g);
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            u = UW'($urandom_range(0, 64));
            if (i == 0) ch_exp = u;
            exp_q.push_back({AW'(i * geff), d});
            if (stall_p > 0) repeat ($urandom_range(0, 1)) tick();
            offer(d, u, (i == tlast_idx), 200, ok);
            chk("beat_accept", ok, 1'b1);
            if (!ok) break;
            if (i == 0) begin
                c1 = cyc;
                if (hold > 0) stall_hold = hold;
            end
            if (hold > 0 && i == 1) chk("second_beat_buffered", cyc, c1 + 1);
            if (hold > 0 && i == 2) chk("no_accept_while_full", (cyc > c1 + hold), 1'b1);
        end
        offer({$urandom, $urandom}, '0, 1'b0, 6, ok);
        chk("extra_beat_refused", ok, 1'b0);
        for (int c = 0; c < 300 && done_cnt == 0; c++) tick();
        repeat (3) tick();
        chk("done_once", done_cnt, 1);
        chk("all_writes_seen", exp_q.size(), 0);
        chk("err_last", err_last, err_exp);
        if (n > 0) chk("channels", channels, ch_exp);
        if (timing) begin
            chk("first_write_latency", first_wr, c1 + 1);
            chk("writes_back_to_back", last_wr - first_wr, n - 1);
            chk("done_after_last_write", done_cyc, last_wr + 1);
        end
        exp_q.delete();
        stall_pct = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        logic [DW-1:0] d;
        int sz, g;
        rst           = 1'b1;
        start_input   = 1'b0;
        in_size       = '0;
        groups        = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        repeat (3) tick();
        chk("reset_tready", s_axis_tready, 1'b0);
        chk("reset_en", sram_in_en, 1'b0);
        chk("reset_done", input_done, 1'b0);
        chk("reset_channels", channels, '0);
        chk("reset_err_last", err_last, 1'b0);
        chk("reset_addr", sram_in_addr, '0);
        rst = 1'b0;
        tick();

        // back-to-back, no stall
        run_xfer(8, 2, 3, 0, 0, 1'b1);
        // stall held after beat 1
        run_xfer(8, 2, 3, 0, 5, 1'b0);
        // partial final beat
        run_xfer(5, 2, 2, 0, 0, 1'b0);

        // abort after 2 beats, then rearm
        arm(16, 2);
        for (int i = 0; i < 2; i++) begin
            d = {$urandom, $urandom};
            exp_q.push_back({AW'(i * 2), d});
            offer(d, 7'd3, 1'b0, 200, ok);
            chk("abort_beat_accept", ok, 1'b1);
        end
        repeat (4) tick();
        start_input = 1'b0;
        repeat (10) tick();
        chk("abort_tready", s_axis_tready, 1'b0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_writes", exp_q.size(), 0);
        exp_q.delete();
        run_xfer(4, 1, 3, 0, 0, 1'b0);

        // tlast on beat 2 of 4, and final beat missing tlast
        run_xfer(8, 2, 1, 0, 0, 1'b0);
        run_xfer(6, 3, -1, 0, 0, 1'b0);
        // in_size 0 and groups 0
        run_xfer(0, 4, -1, 0, 0, 1'b0);
        run_xfer(3, 0, 2, 0, 0, 1'b0);

        // randomized transfers with random stall
        for (int k = 0; k < 8; k++) begin
            sz = $urandom_range(1, 40);
            g  = $urandom_range(0, 15);
            run_xfer(sz, g, (sz + ((g == 0) ? 1 : g) - 1) / ((g == 0) ? 1 : g) - 1, 30, 0, 1'b0);
        end

        // async reset mid-RECV
        arm(32, 1);
        offer({$urandom, $urandom}, 7'd1, 1'b0, 200, ok);
        stall_hold = 20;
        offer({$urandom, $urandom}, 7'd1, 1'b0, 200, ok);
        rst = 1'b1;
        start_input = 1'b0;
        #1;
        chk("rst_mid_tready", s_axis_tready, 1'b0);
        chk("rst_mid_en", sram_in_en, 1'b0);
        chk("rst_mid_done", input_done, 1'b0);
        exp_q.delete();
        stall_hold = 0;
        repeat (2) tick();
        rst = 1'b0;
        run_xfer(6, 2, 2, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
